// File: rtl/gcd_unit.sv
// GCD engine: one job at a time, valid/ready on both sides, selectable
// subtractive Euclid (MODE 0) or binary Stein (MODE 1) datapath.
module gcd_unit #(
  parameter int WIDTH = 16,
  parameter int MODE  = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] cycles,
  output logic             busy
);

  localparam int KW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {IDLE, TEST, SWAP, SUBT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [KW-1:0]    k_reg, k_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic [CNT_W-1:0] cycles_reg, cycles_next;
  logic [CNT_W-1:0] cycles_inc;

  assign cycles_inc = (cycles_reg == {CNT_W{1'b1}}) ? cycles_reg : cycles_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      k_reg      <= '0;
      result_reg <= '0;
      cycles_reg <= '0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      k_reg      <= k_next;
      result_reg <= result_next;
      cycles_reg <= cycles_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    k_next      = k_reg;
    result_next = result_reg;
    cycles_next = cycles_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          a_next      = in_a;
          b_next      = in_b;
          k_next      = '0;
          cycles_next = '0;
          state_next  = TEST;
        end
      end
      TEST: begin
        cycles_next = cycles_inc;
        // k stays 0 in MODE 0, so the shift is a no-op there.
        if (a_reg == '0 || b_reg == '0) begin
          result_next = (a_reg | b_reg) << k_reg;
          state_next  = DONE;
        end else if (a_reg == b_reg) begin
          result_next = a_reg << k_reg;
          state_next  = DONE;
        end else if (MODE == 1 && !a_reg[0] && !b_reg[0]) begin
          a_next = a_reg >> 1;
          b_next = b_reg >> 1;
          k_next = k_reg + 1'b1;
        end else if (MODE == 1 && !a_reg[0]) begin
          a_next = a_reg >> 1;
        end else if (MODE == 1 && !b_reg[0]) begin
          b_next = b_reg >> 1;
        end else if (a_reg < b_reg) begin
          state_next = SWAP;
        end else begin
          state_next = SUBT;
        end
      end
      SWAP: begin
        cycles_next = cycles_inc;
        a_next      = b_reg;
        b_next      = a_reg;
        state_next  = SUBT;
      end
      SUBT: begin
        cycles_next = cycles_inc;
        a_next      = a_reg - b_reg;
        state_next  = TEST;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == TEST) || (state_reg == SWAP) || (state_reg == SUBT);
  assign result    = result_reg;
  assign cycles    = cycles_reg;

endmodule

// File: tb/tb_gcd_unit.sv
// Bench for gcd_unit: three instances (Euclid, Stein, Euclid with 4-bit counter)
// driven with directed and random jobs against an arithmetic reference model.
module tb_gcd_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        iv   [3];
  logic        ordy [3];
  logic        ir   [3];
  logic        ov   [3];
  logic        bz   [3];
  logic [15:0] res  [3];
  logic [15:0] cy0, cy1;
  logic [3:0]  cy2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gcd_unit #(.WIDTH(16), .MODE(0), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .in_a(in_a), .in_b(in_b),
    .out_valid(ov[0]), .out_ready(ordy[0]), .result(res[0]), .cycles(cy0), .busy(bz[0]));
  gcd_unit #(.WIDTH(16), .MODE(1), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .in_a(in_a), .in_b(in_b),
    .out_valid(ov[1]), .out_ready(ordy[1]), .result(res[1]), .cycles(cy1), .busy(bz[1]));
  gcd_unit #(.WIDTH(16), .MODE(0), .CNT_W(4)) u2 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .in_a(in_a), .in_b(in_b),
    .out_valid(ov[2]), .out_ready(ordy[2]), .result(res[2]), .cycles(cy2), .busy(bz[2]));

  function automatic logic [15:0] get_cy(input int idx);
    if (idx == 0) return cy0;
    if (idx == 1) return cy1;
    return {12'b0, cy2};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Mathematical gcd by repeated modulo, independent of either hardware algorithm.
  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Step count: one per TEST visit, SWAP and SUBT, following the algorithm rules.
  function automatic int ref_cycles(input int a, input int b, input int mode);
    int n = 0;
    int t;
    forever begin
      n++;
      if (a == 0 || b == 0 || a == b) return n;
      if (mode == 1 && a % 2 == 0 && b % 2 == 0) begin a /= 2; b /= 2; end
      else if (mode == 1 && a % 2 == 0) a /= 2;
      else if (mode == 1 && b % 2 == 0) b /= 2;
      else begin
        if (a < b) begin t = a; a = b; b = t; n++; end
        a -= b;
        n++;
      end
    end
  endfunction

  task automatic run_job(input int idx, input int a, input int b, input int hold);
    int exp_r, exp_c, sat, e;
    exp_r = ref_gcd(a, b);
    exp_c = ref_cycles(a, b, (idx == 1) ? 1 : 0);
    sat   = (idx == 2) ? 15 : 65535;
    @(negedge clk);
    check("in_ready_before_job", ir[idx], 1);
    in_a = a[15:0];
    in_b = b[15:0];
    iv[idx] = 1'b1;
    if (hold > 0) ordy[idx] = 1'b0;
    @(posedge clk);
    #1;
    iv[idx] = 1'b0;
    in_a = 16'($urandom);
    in_b = 16'($urandom);
    @(negedge clk);
    check("busy_after_accept", bz[idx], 1);
    e = 0;
    while (!ov[idx] && e < 3000) begin
      @(negedge clk);
      e++;
    end
    check("done_within_budget", (e < 3000) ? 1 : 0, 1);
    check("result", res[idx], exp_r);
    check("cycles", get_cy(idx), (exp_c > sat) ? sat : exp_c);
    if (exp_c <= sat) check("latency", e, exp_c);
    $display("job dut%0d a=%0d b=%0d result=%0d cycles=%0d latency=%0d",
             idx, a, b, res[idx], get_cy(idx), e);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_out_valid", ov[idx], 1);
      check("hold_in_ready", ir[idx], 0);
      check("hold_result", res[idx], exp_r);
      check("hold_cycles", get_cy(idx), (exp_c > sat) ? sat : exp_c);
    end
    ordy[idx] = 1'b1;
    @(negedge clk);
    check("out_valid_drops", ov[idx], 0);
    check("in_ready_returns", ir[idx], 1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i]   = 1'b0;
      ordy[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("reset_in_ready", ir[i], 1);
      check("reset_out_valid", ov[i], 0);
      check("reset_busy", bz[i], 0);
      check("reset_result", res[i], 0);
      check("reset_cycles", get_cy(i), 0);
    end

    // Directed jobs from the plan.
    run_job(0, 6, 4, 0);
    run_job(0, 12, 12, 0);
    run_job(0, 0, 9, 0);
    run_job(0, 0, 0, 0);
    run_job(1, 12, 8, 0);
    run_job(0, 6, 4, 5);

    // Reset while the (6,4) job sits in SWAP.
    @(negedge clk);
    in_a = 16'd6;
    in_b = 16'd4;
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("busy_before_reset", bz[0], 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midjob_reset_out_valid", ov[0], 0);
    check("midjob_reset_in_ready", ir[0], 1);
    check("midjob_reset_cycles", cy0, 0);
    check("midjob_reset_result", res[0], 0);
    check("midjob_reset_busy", bz[0], 0);
    run_job(0, 15, 10, 0);

    run_job(2, 15, 1, 0);

    // Random jobs; Euclid operands kept small so subtract chains stay short.
    for (int j = 0; j < 15; j++) run_job(0, $urandom_range(0, 255), $urandom_range(0, 255), 0);
    for (int j = 0; j < 15; j++) run_job(1, $urandom_range(0, 65535), $urandom_range(0, 65535), 0);
    for (int j = 0; j < 8; j++)  run_job(2, $urandom_range(0, 40), $urandom_range(0, 40), j % 3);
    for (int j = 0; j < 4; j++)  run_job(1, $urandom_range(0, 300), $urandom_range(0, 300), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
